// File: rtl/nn_pkg.sv
// Shared types and constant helpers for the MAC accumulator array.
package nn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic longint sat_max(input int width);
      return (longint'(1) <<< (width - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int width);
      return -(longint'(1) <<< (width - 1));
   endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: accumulates a*b, then floor-shifts and saturates into a registered result.
// The result register loads only on the final beat, so it stays steady while the consumer stalls.
module mac_lane
   import nn_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int ACC_WIDTH = 40,
   parameter int FRAC      = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic                    add,
   input  logic                    capture,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] out,
   output logic                    sat
);

   localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(sat_max(WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(sat_min(WIDTH));

   logic signed [2*WIDTH-1:0]   prod;
   logic signed [ACC_WIDTH-1:0] prod_ext;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] acc_next;
   logic signed [ACC_WIDTH-1:0] shifted;
   logic signed [WIDTH-1:0]     sat_val;
   logic                        sat_flag;

   assign prod     = a * b;
   assign prod_ext = ACC_WIDTH'(prod);
   assign acc_next = load ? prod_ext : acc + prod_ext;
   // Result is formed from acc_next so the final beat's product is included.
   assign shifted  = acc_next >>> FRAC;

   always_comb begin
      sat_val  = shifted[WIDTH-1:0];
      sat_flag = 1'b0;
      if (shifted > MAX_V) begin
         sat_val  = MAX_V[WIDTH-1:0];
         sat_flag = 1'b1;
      end else if (shifted < MIN_V) begin
         sat_val  = MIN_V[WIDTH-1:0];
         sat_flag = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         out <= '0;
         sat <= 1'b0;
      end else begin
         if (load || add) acc <= acc_next;
         if (capture) begin
            out <= sat_val;
            sat <= sat_flag;
         end
      end
   end

endmodule

// File: rtl/mac_array_acc.sv
// LANES-wide MAC array: accumulates cfg_len beats, result valid 1 cycle after the last beat.
// in_ready drops while a result is held; the result is held until out_ready accepts it.
module mac_array_acc
   import nn_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int LANES     = 4,
   parameter int ACC_WIDTH = 40,
   parameter int MAX_LEN   = 256,
   parameter int FRAC      = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [clog2(MAX_LEN+1)-1:0]    cfg_len,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [LANES*WIDTH-1:0]         a,
   input  logic [LANES*WIDTH-1:0]         b,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [LANES*WIDTH-1:0]         out,
   output logic [LANES-1:0]               out_sat
);

   localparam int LEN_W = clog2(MAX_LEN + 1);

   if (ACC_WIDTH < 2*WIDTH + clog2(MAX_LEN)) begin : g_acc_width_check
      $error("mac_array_acc: ACC_WIDTH too narrow, accumulator could wrap");
   end

   state_t           state;
   state_t           state_next;
   logic [LEN_W-1:0] count;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] eff_len;
   logic [LEN_W-1:0] count_inc;
   logic             accept;
   logic             xfer;
   logic             last_beat;
   logic             lane_load;
   logic             lane_add;

   assign eff_len   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
   assign count_inc = count + LEN_W'(1);
   assign accept    = in_valid & in_ready;
   assign xfer      = out_valid & out_ready;
   assign last_beat = accept & ((state == IDLE) ? (eff_len == LEN_W'(1)) : (count_inc == len_q));
   assign lane_load = accept & (state == IDLE);
   assign lane_add  = accept & (state == ACCUM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = last_beat ? HOLD : ACCUM;
         ACCUM:   if (last_beat) state_next = HOLD;
         HOLD:    if (xfer) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE, ACCUM: in_ready = !rst;
         HOLD:        out_valid = 1'b1;
         default:     ;
      endcase
   end

   // Length is latched on the first beat so later cfg_len changes cannot disturb it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         len_q <= '0;
      end else if (accept) begin
         if (state == IDLE) begin
            len_q <= eff_len;
            count <= LEN_W'(1);
         end else begin
            count <= count_inc;
         end
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      mac_lane #(
         .WIDTH     (WIDTH),
         .ACC_WIDTH (ACC_WIDTH),
         .FRAC      (FRAC)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .load    (lane_load),
         .add     (lane_add),
         .capture (last_beat),
         .a       (a[i*WIDTH +: WIDTH]),
         .b       (b[i*WIDTH +: WIDTH]),
         .out     (out[i*WIDTH +: WIDTH]),
         .sat     (out_sat[i])
      );
   end

endmodule
